// File: rtl/fm_hop_sequencer.sv
// fm_hop_sequencer
//   Frequency-hopping controller. Walks a small {carrier increment, dwell}
//   table; for every entry it issues one pipelined Wishbone write to the
//   generator's carrier-centre register (address 0) and then dwells for the
//   programmed number of cycles (a dwell of 0 behaves as 1).
//
//   Optional build macro FM_HOP_ACK_TIMEOUT_EN: adds an ack watchdog in
//   WB_WAIT. After TIMEOUT_CYCLES cycles without ack the cycle is dropped,
//   o_error is set (sticky until the next accepted start) and the sequencer
//   returns to IDLE. Without the macro WB_WAIT waits forever, o_error = 0.
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_tbl_we/addr/freq/dwell table write port (usable while running)
//   i_last_index, i_loop    sequence end index and wrap enable
//   i_start, i_stop         single-cycle control pulses (stop wins)
//   o_wb_*, i_wb_ack/stall  Wishbone master towards the generator
//   o_busy                  sequencer not idle
//   o_index                 current table entry
//   o_hop_strobe            one-cycle pulse on the first cycle of each dwell
//   o_error                 sticky ack-timeout flag
module fm_hop_sequencer #(
  parameter int TBL_AW         = 4,
  parameter int DWELL_W        = 24,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tbl_we,
  input  logic [TBL_AW-1:0]  i_tbl_addr,
  input  logic [31:0]        i_tbl_freq,
  input  logic [DWELL_W-1:0] i_tbl_dwell,
  input  logic [TBL_AW-1:0]  i_last_index,
  input  logic               i_loop,
  input  logic               i_start,
  input  logic               i_stop,
  output logic               o_wb_cyc,
  output logic               o_wb_stb,
  output logic               o_wb_we,
  output logic [1:0]         o_wb_addr,
  output logic [31:0]        o_wb_data,
  input  logic               i_wb_ack,
  input  logic               i_wb_stall,
  output logic               o_busy,
  output logic [TBL_AW-1:0]  o_index,
  output logic               o_hop_strobe,
  output logic               o_error
);

  localparam int DEPTH = 2 ** TBL_AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WB_REQ,
    S_WB_WAIT,
    S_DWELL
  } state_t;

  logic [31:0]        tbl_freq  [DEPTH];
  logic [DWELL_W-1:0] tbl_dwell [DEPTH];

  state_t             state_q, state_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic [31:0]        data_q, data_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [TBL_AW-1:0]  index_q, index_d;
  logic               hop_q, hop_d;
  logic               stop_pend_q, stop_pend_d;
  logic               start_ok;
  logic               timeout;

  // Table RAM: no reset. Reads happen in FETCH and are captured into the
  // bus data / dwell registers, so a same-cycle write returns the old entry.
  always_ff @(posedge i_clk) begin
    if (i_tbl_we) begin
      tbl_freq[i_tbl_addr]  <= i_tbl_freq;
      tbl_dwell[i_tbl_addr] <= i_tbl_dwell;
    end
  end

  assign start_ok = (state_q == S_IDLE) && i_start && !i_stop;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      data_q      <= '0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      index_q     <= '0;
      hop_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      data_q      <= data_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      index_q     <= index_d;
      hop_q       <= hop_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    data_d      = data_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    index_d     = index_q;
    hop_d       = 1'b0;
    stop_pend_d = stop_pend_q;

    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (start_ok) begin
          index_d = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (i_stop) begin
          state_d = S_IDLE;
        end else begin
          data_d  = tbl_freq[index_q];
          dwell_d = tbl_dwell[index_q];
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = S_WB_REQ;
        end
      end

      S_WB_REQ: begin
        // A stop here is deferred: the bus cycle is always completed.
        if (i_stop) stop_pend_d = 1'b1;
        if (!i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = S_WB_WAIT;
        end
      end

      S_WB_WAIT: begin
        if (i_stop) stop_pend_d = 1'b1;
        if (i_wb_ack) begin
          cyc_d = 1'b0;
          if (stop_pend_q || i_stop) begin
            state_d = S_IDLE;
          end else begin
            hop_d   = 1'b1;
            cnt_d   = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
            state_d = S_DWELL;
          end
        end else if (timeout) begin
          cyc_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_DWELL: begin
        if (i_stop) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q <= DWELL_W'(1)) begin
          cnt_d = '0;
          if (index_q != i_last_index) begin
            index_d = index_q + TBL_AW'(1);
            state_d = S_FETCH;
          end else if (i_loop) begin
            index_d = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end

      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef FM_HOP_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q;
  logic          err_q;

  // Counts WB_WAIT cycles; fires on the TIMEOUT_CYCLES-th cycle without ack.
  assign timeout = (state_q == S_WB_WAIT) && !i_wb_ack &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_WB_WAIT) tmo_q <= tmo_q + TW'(1);
      else                      tmo_q <= '0;
      if (start_ok)     err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end

  assign o_error = err_q;
`else
  assign timeout = 1'b0;
  assign o_error = 1'b0;
`endif

  assign o_wb_cyc     = cyc_q;
  assign o_wb_stb     = stb_q;
  assign o_wb_we      = cyc_q;
  assign o_wb_addr    = 2'd0;
  assign o_wb_data    = data_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_index      = index_q;
  assign o_hop_strobe = hop_q;

endmodule

// File: tb/tb_fm_hop_sequencer.sv
// Directed bench for fm_hop_sequencer with a one-cycle registered-ack slave.
module tb_fm_hop_sequencer;

  localparam int TBL_AW  = 4;
  localparam int DWELL_W = 24;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               tbl_we = 1'b0;
  logic [TBL_AW-1:0]  tbl_addr = '0;
  logic [31:0]        tbl_freq = '0;
  logic [DWELL_W-1:0] tbl_dwell = '0;
  logic [TBL_AW-1:0]  last_index = '0;
  logic               loop_en = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               wb_cyc, wb_stb, wb_we;
  logic [1:0]         wb_addr;
  logic [31:0]        wb_data;
  logic               wb_ack;
  logic               wb_stall = 1'b0;
  logic               busy;
  logic [TBL_AW-1:0]  index;
  logic               hop;
  logic               error;

  logic slave_ack;
  logic force_ack = 1'b0;
  logic ack_en = 1'b1;
  int   hop_cnt = 0;
  int   ack_cnt = 0;
  int   h0, a0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fm_hop_sequencer #(
    .TBL_AW(TBL_AW),
    .DWELL_W(DWELL_W),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_tbl_we(tbl_we),
    .i_tbl_addr(tbl_addr),
    .i_tbl_freq(tbl_freq),
    .i_tbl_dwell(tbl_dwell),
    .i_last_index(last_index),
    .i_loop(loop_en),
    .i_start(start),
    .i_stop(stop),
    .o_wb_cyc(wb_cyc),
    .o_wb_stb(wb_stb),
    .o_wb_we(wb_we),
    .o_wb_addr(wb_addr),
    .o_wb_data(wb_data),
    .i_wb_ack(wb_ack),
    .i_wb_stall(wb_stall),
    .o_busy(busy),
    .o_index(index),
    .o_hop_strobe(hop),
    .o_error(error)
  );

  // Slave: registered ack one cycle after an accepted strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) slave_ack <= 1'b0;
    else     slave_ack <= ack_en && wb_cyc && wb_stb && !wb_stall;
  end
  assign wb_ack = slave_ack | force_ack;

  always @(posedge clk) begin
    if (hop)    hop_cnt <= hop_cnt + 1;
    if (wb_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tbl_write(input logic [TBL_AW-1:0] a, input logic [31:0] f,
                           input logic [DWELL_W-1:0] d);
    tbl_we = 1'b1; tbl_addr = a; tbl_freq = f; tbl_dwell = d;
    step(1);
    tbl_we = 1'b0;
  endtask

  initial begin
    // Reset state before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_cyc", 32'(wb_cyc), 32'd0);
    check("rst_stb", 32'(wb_stb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_index", 32'(index), 32'd0);
    check("rst_hop", 32'(hop), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_data", wb_data, 32'd0);
    step(2);
    rst = 1'b0;
    step(1);

    // Single pass, no stall
    tbl_write(0, 32'h444444, 5);
    tbl_write(1, 32'h555555, 2);
    last_index = 1; loop_en = 1'b0; ack_en = 1'b1;
    h0 = hop_cnt;
    start = 1'b1; step(1); start = 1'b0;          // N+1
    check("sp_busy_n1", 32'(busy), 32'd1);
    check("sp_cyc_n1", 32'(wb_cyc), 32'd0);
    step(1);                                       // N+2
    check("sp_stb_n2", 32'(wb_stb), 32'd1);
    check("sp_cyc_n2", 32'(wb_cyc), 32'd1);
    check("sp_we_n2", 32'(wb_we), 32'd1);
    check("sp_addr_n2", 32'(wb_addr), 32'd0);
    check("sp_data_n2", wb_data, 32'h444444);
    step(1);                                       // N+3
    check("sp_stb_n3", 32'(wb_stb), 32'd0);
    check("sp_cyc_n3", 32'(wb_cyc), 32'd1);
    check("sp_ack_n3", 32'(wb_ack), 32'd1);
    step(1);                                       // N+4
    check("sp_hop_n4", 32'(hop), 32'd1);
    check("sp_cyc_n4", 32'(wb_cyc), 32'd0);
    step(1);                                       // N+5
    check("sp_hop_n5", 32'(hop), 32'd0);
    step(5);                                       // N+10
    check("sp_stb_n10", 32'(wb_stb), 32'd1);
    check("sp_data_n10", wb_data, 32'h555555);
    check("sp_index_n10", 32'(index), 32'd1);
    step(3);                                       // N+13
    check("sp_busy_n13", 32'(busy), 32'd1);
    step(1);                                       // N+14
    check("sp_busy_n14", 32'(busy), 32'd0);
    check("sp_hops", 32'(hop_cnt - h0), 32'd2);

    // Stall hold: 3 stall cycles on the first request
    last_index = 0; loop_en = 1'b0; wb_stall = 1'b1;
    h0 = hop_cnt; a0 = ack_cnt;
    start = 1'b1; step(1); start = 1'b0;          // N+1
    step(1);                                       // N+2
    for (int k = 0; k < 4; k++) begin              // N+2 .. N+5
      check("st_stb", 32'(wb_stb), 32'd1);
      check("st_addr", 32'(wb_addr), 32'd0);
      check("st_data", wb_data, 32'h444444);
      if (k == 3) wb_stall = 1'b0;
      step(1);
    end                                            // N+6
    check("st_stb_n6", 32'(wb_stb), 32'd0);
    check("st_cyc_n6", 32'(wb_cyc), 32'd1);
    step(1);                                       // N+7
    check("st_hop_n7", 32'(hop), 32'd1);
    step(5);                                       // N+12
    check("st_busy_end", 32'(busy), 32'd0);
    check("st_acks", 32'(ack_cnt - a0), 32'd1);
    check("st_hops", 32'(hop_cnt - h0), 32'd1);

    // Loop with dwell=0; a write colliding with FETCH returns the old entry
    tbl_write(0, 32'h123456, 0);
    last_index = 0; loop_en = 1'b1;
    h0 = hop_cnt;
    start = 1'b1; step(1); start = 1'b0;          // N+1 (FETCH)
    tbl_we = 1'b1; tbl_addr = 0; tbl_freq = 32'hABCDEF; tbl_dwell = 0;
    step(1); tbl_we = 1'b0;                        // N+2
    check("lp_data_old", wb_data, 32'h123456);
    check("lp_stb_n2", 32'(wb_stb), 32'd1);
    step(4);                                       // N+6
    check("lp_stb_n6", 32'(wb_stb), 32'd1);
    check("lp_data_new", wb_data, 32'hABCDEF);
    check("lp_index_n6", 32'(index), 32'd0);
    step(4);                                       // N+10
    check("lp_stb_n10", 32'(wb_stb), 32'd1);
    check("lp_index_n10", 32'(index), 32'd0);
    step(2);                                       // N+12
    check("lp_hop_n12", 32'(hop), 32'd1);
    stop = 1'b1; step(1); stop = 1'b0;             // N+13
    check("lp_busy_stop", 32'(busy), 32'd0);
    check("lp_cyc_stop", 32'(wb_cyc), 32'd0);
    check("lp_hops", 32'(hop_cnt - h0), 32'd3);

    // Stop during WB_WAIT: cycle completes on ack, no hop strobe
    tbl_write(0, 32'h444444, 5);
    ack_en = 1'b0;
    h0 = hop_cnt;
    start = 1'b1; step(1); start = 1'b0;          // N+1
    step(2);                                       // N+3
    check("sw_cyc_n3", 32'(wb_cyc), 32'd1);
    check("sw_stb_n3", 32'(wb_stb), 32'd0);
    stop = 1'b1; step(1); stop = 1'b0;             // N+4
    check("sw_busy_n4", 32'(busy), 32'd1);
    check("sw_cyc_n4", 32'(wb_cyc), 32'd1);
    step(2);                                       // N+6
    check("sw_cyc_n6", 32'(wb_cyc), 32'd1);
    force_ack = 1'b1; step(1); force_ack = 1'b0;   // N+7
    check("sw_cyc_n7", 32'(wb_cyc), 32'd0);
    check("sw_busy_n7", 32'(busy), 32'd0);
    check("sw_hop_n7", 32'(hop), 32'd0);
    step(2);
    check("sw_hops", 32'(hop_cnt - h0), 32'd0);
    ack_en = 1'b1;

    // Start and stop together in IDLE
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy), 32'd0);
    step(2);
    check("ss_cyc", 32'(wb_cyc), 32'd0);
    check("ss_busy2", 32'(busy), 32'd0);

    // Stop during DWELL (dwell 5, looping)
    start = 1'b1; step(1); start = 1'b0;          // N+1
    step(5);                                       // N+6
    check("sd_busy_n6", 32'(busy), 32'd1);
    check("sd_cyc_n6", 32'(wb_cyc), 32'd0);
    stop = 1'b1; step(1); stop = 1'b0;             // N+7
    check("sd_busy_n7", 32'(busy), 32'd0);
    step(3);                                       // N+10
    check("sd_stb_n10", 32'(wb_stb), 32'd0);

`ifdef FM_HOP_ACK_TIMEOUT_EN
    // Ack watchdog
    ack_en = 1'b0;
    start = 1'b1; step(1); start = 1'b0;          // N+1
    step(16);                                      // N+17
    check("to_cyc_n17", 32'(wb_cyc), 32'd1);
    check("to_err_n17", 32'(error), 32'd0);
    step(1);                                       // N+18
    check("to_cyc_n18", 32'(wb_cyc), 32'd0);
    check("to_err_n18", 32'(error), 32'd1);
    check("to_busy_n18", 32'(busy), 32'd0);
    step(3);
    check("to_err_sticky", 32'(error), 32'd1);
    start = 1'b1; step(1); start = 1'b0;
    check("to_err_clear", 32'(error), 32'd0);
    check("to_busy_restart", 32'(busy), 32'd1);
    step(20);
    check("to_idle_again", 32'(busy), 32'd0);
    ack_en = 1'b1;
`endif

    // Asynchronous reset while stuck in WB_WAIT on entry 1
    tbl_write(0, 32'h444444, 1);
    last_index = 1; loop_en = 1'b0; ack_en = 1'b1;
    start = 1'b1; step(1); start = 1'b0;          // N+1
    step(2);                                       // N+3
    ack_en = 1'b0;
    step(5);                                       // N+8
    check("ar_index_pre", 32'(index), 32'd1);
    check("ar_cyc_pre", 32'(wb_cyc), 32'd1);
    check("ar_busy_pre", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_cyc", 32'(wb_cyc), 32'd0);
    check("ar_stb", 32'(wb_stb), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_hop", 32'(hop), 32'd0);
    check("ar_index", 32'(index), 32'd0);
    step(2);
    rst = 1'b0;
    step(2);
    check("ar_busy_after", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
